rf_write_arbiter: RTL

//  Shares the single register-file write port (write/wr/wd) between the pipeline writeback stage and the

---
 rtl/rf_write_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the writeback stage has priority, multiply/divide results wait in a small FIFO.
// It also holds a pending-write scoreboard for MD destinations and raises stall_req when the FIFO is starved too long.
module rf_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_wr,
    input  logic [31:0] wb_wd,
    input  logic        md_valid,
    input  logic [4:0]  md_wr,
    input  logic [31:0] md_wd,
    output logic        md_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_wr,
    input  logic [4:0]  pr1,
    input  logic [4:0]  pr2,
    output logic        busy1,
    output logic        busy2,
    output logic        stall_req,
    output logic        write,
    output logic [4:0]  wr,
    output logic [31:0] wd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [PW:0]   FULL_COUNT  = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_MAX - 1);

    typedef struct packed {
        logic [4:0]  wr;
        logic [31:0] wd;
    } md_entry_t;

    typedef enum logic {
        NORMAL,
        STARVED
    } state_t;

    md_entry_t     fifo_mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic [31:0]   pend_q, pend_d;
    logic [CW-1:0] starve_cnt_q;
    state_t        state_q;
    logic          stall_q;
    logic          write_q;
    logic [4:0]    wr_q;
    logic [31:0]   wd_q;

    logic      wb_req;
    logic      fifo_nonempty;
    logic      push;
    logic      pop;
    md_entry_t head;

    assign wb_req        = wb_valid && (wb_wr != 5'd0);
    assign fifo_nonempty = (count_q != '0);
    assign head          = fifo_mem_q[rptr_q];
    assign pop           = !wb_req && fifo_nonempty;
    assign md_ready      = !reset && (count_q < FULL_COUNT);
    assign push          = md_valid && md_ready;

    assign busy1     = pend_q[pr1] && (pr1 != 5'd0);
    assign busy2     = pend_q[pr2] && (pr2 != 5'd0);
    assign stall_req = stall_q;
    assign write     = write_q;
    assign wr        = wr_q;
    assign wd        = wd_q;

    // NOTE: FIFO storage carries no reset; the pointers and count define validity, so stale data is never read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wptr_q] <= '{wr: md_wr, wd: md_wd};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: next-state gets a full default before any conditional update, so no latch is inferred.
    always_comb begin
        pend_d = pend_q;
        if (pop && (head.wr != 5'd0)) pend_d[head.wr] = 1'b0;
        // A set on the same register in the same cycle overrides the clear.
        if (issue_valid && (issue_wr != 5'd0)) pend_d[issue_wr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q <= 1'b0;
            wr_q    <= '0;
            wd_q    <= '0;
        end else if (wb_req) begin
            write_q <= 1'b1;
            wr_q    <= wb_wr;
            wd_q    <= wb_wd;
        end else if (pop) begin
            // A head entry targeting r0 still drains, but never strobes the port.
            write_q <= (head.wr != 5'd0);
            if (head.wr != 5'd0) begin
                wr_q <= head.wr;
                wd_q <= head.wd;
            end
        end else begin
            write_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= NORMAL;
            starve_cnt_q <= '0;
            stall_q      <= 1'b0;
        end else begin
            unique case (state_q)
                NORMAL: begin
                    if (pop || !fifo_nonempty) begin
                        starve_cnt_q <= '0;
                    end else if (starve_cnt_q == STARVE_LAST) begin
                        state_q <= STARVED;
                        stall_q <= 1'b1;
                    end else begin
                        starve_cnt_q <= starve_cnt_q + CW'(1);
                    end
                end
                STARVED: begin
                    // The hold ends once a pipeline bubble hands the port to the FIFO head.
                    if (pop) begin
                        state_q      <= NORMAL;
                        starve_cnt_q <= '0;
                        stall_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= NORMAL;
                end
            endcase
        end
    end

endmodule
